// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator with run-time rate, rounding shift and output saturation.
module cic_decimator #(
  parameter int dsz = 14,
  parameter int osz = 16,
  parameter int N   = 4,
  parameter int rsz = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic signed [dsz-1:0] in,
  input  logic [rsz-1:0]        rate,
  input  logic [5:0]            shift,
  output logic signed [osz-1:0] out,
  output logic                  out_valid
);
  localparam int asz = dsz + N * rsz;
  localparam logic signed [asz:0] hi = (asz+1)'(2 ** (osz - 1) - 1);
  localparam logic signed [asz:0] lo = (asz+1)'(-(2 ** (osz - 1)));
  logic signed [asz-1:0] integ [N];
  logic signed [asz-1:0] dly [N];
  logic signed [asz-1:0] comb [N];
  logic signed [asz-1:0] samp;
  logic signed [asz:0]   y, rnd, ce;
  logic [N-1:0]          cv;
  logic                  sv, yv, cap;
  logic [rsz-1:0]        cnt;
  logic [5:0]            sh;
  // >= rather than == so a rate lowered below cnt wraps on the next accepted sample
  always_comb begin
    cap = ena && cnt >= rate;
    sh  = shift > 6'(asz - osz) ? 6'(asz - osz) : shift;
    rnd = sh == 6'd0 ? '0 : (asz+1)'(1) << (sh - 6'd1);
    ce  = (asz+1)'(comb[N-1]);
  end
  always_ff @(posedge clk)
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
        comb[k]  <= '0;
      end
      samp      <= '0;
      cnt       <= '0;
      cv        <= '0;
      sv        <= 1'b0;
      yv        <= 1'b0;
      y         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ena) begin
        integ[0] <= integ[0] + asz'(in);
        for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
        cnt <= cap ? '0 : cnt + 1'b1;
      end
      if (cap) samp <= integ[N-1];
      sv <= cap;
      if (sv) begin
        comb[0] <= samp - dly[0];
        dly[0]  <= samp;
      end
      for (int k = 1; k < N; k++)
        if (cv[k-1]) begin
          comb[k] <= comb[k-1] - dly[k];
          dly[k]  <= comb[k-1];
        end
      cv <= {cv[N-2:0], sv};
      if (cv[N-1]) y <= (ce + rnd) >>> sh;
      yv <= cv[N-1];
      if (yv) out <= y > hi ? hi[osz-1:0] : y < lo ? lo[osz-1:0] : y[osz-1:0];
      out_valid <= yv;
    end
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed checks of latency, period, DC gain, saturation, gating and reset.
module tb_cic_decimator;
  logic clk = 1'b0, reset = 1'b1, ena = 1'b0;
  logic signed [13:0] in = '0;
  logic [7:0] rate = 8'd3;
  logic [5:0] shift = 6'd8;
  logic signed [15:0] out;
  logic out_valid;
  int checks = 0, failures = 0;
  int n, pulses, last;

  cic_decimator dut (
    .clk(clk), .reset(reset), .ena(ena), .in(in), .rate(rate),
    .shift(shift), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ov(input int lim, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt < lim);
  endtask

  task automatic restart(input logic [7:0] r, input logic [5:0] s, input logic signed [13:0] x);
    reset = 1'b1;
    ena = 1'b0;
    tick();
    rate = r;
    shift = s;
    in = x;
    ena = 1'b1;
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    check("reset_out", out, 0);
    check("reset_ov", out_valid, 0);
    // unit DC gain, R=4: first pulse 10 edges after release, then every 4
    restart(8'd3, 6'd8, 14'sd100);
    wait_ov(20, n);
    check("dc_latency", n, 10);
    for (int i = 2; i <= 7; i++) begin
      wait_ov(8, n);
      check("dc_period", n, 4);
      if (i >= 5) check("dc_out", out, 100);
    end
    tick();
    check("hold_ov", out_valid, 0);
    check("hold_out", out, 100);
    // live rate change from 255 to 3 at cnt=200
    restart(8'd255, 6'd8, 14'sd100);
    for (int i = 0; i < 200; i++) tick();
    rate = 8'd3;
    wait_ov(20, n);
    check("rate_change_latency", n, 7);
    wait_ov(8, n);
    check("rate_change_period", n, 4);
    // capture two edges before this pulse; reset on the edge two after the following capture
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midreset_out", out, 0);
    check("midreset_ov", out_valid, 0);
    reset = 1'b0;
    wait_ov(20, n);
    check("after_reset_latency", n, 10);
    for (int i = 2; i <= 5; i++) wait_ov(8, n);
    check("after_reset_out", out, 100);
    // R=1 pass-through of a ramp, gain 1
    restart(8'd0, 6'd0, 14'sd0);
    for (int j = 1; j <= 20; j++) begin
      tick();
      in = 14'(j);
      if (j >= 12) begin
        check("ramp_ov", out_valid, 1);
        check("ramp_out", out, j - 11);
      end
    end
    // gated input, R=2, gain 16, shift 4
    restart(8'd1, 6'd4, 14'sd50);
    pulses = 0;
    last = 0;
    for (int i = 0; i < 60; i++) begin
      ena = (i % 2 == 0);
      tick();
      if (out_valid) begin
        pulses++;
        if (pulses >= 2 && pulses <= 6) check("gated_period", i - last, 4);
        if (pulses >= 5 && pulses <= 7) check("gated_out", out, 50);
        last = i;
      end
    end
    check("gated_pulses_seen", pulses >= 7, 1);
    ena = 1'b1;
    // full-scale positive: shift 32 is limited to 30, giving 8191*4
    restart(8'd255, 6'd32, 14'sd8191);
    wait_ov(300, n);
    check("fs_pos_latency", n, 262);
    for (int i = 2; i <= 5; i++) begin
      wait_ov(300, n);
      check("fs_pos_period", n, 256);
    end
    check("fs_pos_clamped_shift", out, 32764);
    shift = 6'd29;
    wait_ov(300, n);
    check("fs_pos_sat", out, 32767);
    // full-scale negative
    restart(8'd255, 6'd29, -14'sd8192);
    for (int i = 1; i <= 5; i++) wait_ov(300, n);
    check("fs_neg_sat", out, -32768);
    shift = 6'd32;
    wait_ov(300, n);
    check("fs_neg_clamped_shift", out, -32768);
    shift = 6'd31;
    wait_ov(300, n);
    check("fs_neg_period", n, 256);
    check("fs_neg_shift31", out, -32768);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
